// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry output register toward
// decode, redirect handling and a latched misaligned-redirect fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [31:0]            instr_addr,
  input  logic [31:0]            instr_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_plus4,
  output logic [31:0]            out_instr,
  output logic                   fault,
  output logic [31:0]            fault_addr,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam logic [31:0] INSTR_NOP = 32'h00000013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_pc, w_pc_nxt;
  logic                   r_out_valid, w_out_valid_nxt;
  logic [31:0]            r_out_pc, w_out_pc_nxt;
  logic [31:0]            r_out_instr, w_out_instr_nxt;
  logic                   r_fault, w_fault_nxt;
  logic [31:0]            r_fault_addr, w_fault_addr_nxt;
  logic [COUNT_WIDTH-1:0] r_fetch_count, w_fetch_count_nxt;
  logic                   w_load;
  logic                   w_misaligned;

  assign w_load       = !r_out_valid || out_ready;
  assign w_misaligned = (redirect_target[1:0] != 2'b00);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0;
      r_out_instr   <= INSTR_NOP;
      r_fault       <= 1'b0;
      r_fault_addr  <= 32'h0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_out_instr   <= w_out_instr_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_addr  <= w_fault_addr_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Next-state and next-datapath values; everything holds unless updated.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_out_valid_nxt   = r_out_valid;
    w_out_pc_nxt      = r_out_pc;
    w_out_instr_nxt   = r_out_instr;
    w_fault_nxt       = r_fault;
    w_fault_addr_nxt  = r_fault_addr;
    w_fetch_count_nxt = r_fetch_count;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect wins over capture and flushes the held instruction.
          w_out_valid_nxt = 1'b0;
          if (w_misaligned) begin
            w_state_nxt      = S_FAULT;
            w_fault_nxt      = 1'b1;
            w_fault_addr_nxt = redirect_target;
          end else begin
            w_pc_nxt = redirect_target;
          end
        end else if (w_load) begin
          w_out_pc_nxt      = r_pc;
          w_out_instr_nxt   = instr_data;
          w_out_valid_nxt   = 1'b1;
          w_pc_nxt          = r_pc + PC_STEP;
          w_fetch_count_nxt = r_fetch_count + COUNT_WIDTH'(1);
        end
      end
      S_FAULT: begin
        w_out_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign instr_addr   = r_pc;
  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc + PC_STEP;
  assign out_instr    = r_out_instr;
  assign fault        = r_fault;
  assign fault_addr   = r_fault_addr;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (default reset PC with a 32-bit counter,
// reset PC 0x100 with a 4-bit counter) against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        rv;
  logic [31:0] rt;

  logic [31:0] addr0, data0, opc0, pp40, ins0, fa0, fc0;
  logic        v0, f0;
  logic [31:0] addr1, data1, opc1, pp41, ins1, fa1;
  logic [3:0]  fc1;
  logic        v1, f1;

  int checks = 0;
  int errors = 0;

  // Memory image: every word is "addi x0,x0,imm" with imm tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[13:2], 20'h00013};
  endfunction

  assign data0 = mem_word(addr0);
  assign data1 = mem_word(addr1);

  fetch_unit u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_addr(addr0), .instr_data(data0),
    .redirect_valid(rv), .redirect_target(rt), .out_valid(v0),
    .out_ready(ready), .out_pc(opc0), .out_pc_plus4(pp40), .out_instr(ins0),
    .fault(f0), .fault_addr(fa0), .fetch_count(fc0)
  );

  fetch_unit #(.RESET_PC(32'h100), .COUNT_WIDTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_addr(addr1), .instr_data(data1),
    .redirect_valid(rv), .redirect_target(rt), .out_valid(v1),
    .out_ready(ready), .out_pc(opc1), .out_pc_plus4(pp41), .out_instr(ins1),
    .fault(f1), .fault_addr(fa1), .fetch_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, one slot per instance.
  logic [31:0] m_pc[2], m_opc[2], m_ins[2], m_fa[2], m_cnt[2];
  logic        m_valid[2], m_fault[2], m_boot[2];

  function automatic logic [31:0] reset_pc(input int k);
    return (k == 0) ? 32'h0 : 32'h100;
  endfunction

  // Model: fetch sequentially, honour stalls, flush on redirect, latch faults.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] <= reset_pc(k); m_opc[k] <= 32'h0; m_ins[k] <= 32'h13;
        m_fa[k] <= 32'h0; m_cnt[k] <= 32'h0; m_valid[k] <= 1'b0;
        m_fault[k] <= 1'b0; m_boot[k] <= 1'b1;
      end else if (m_fault[k]) begin
        m_valid[k] <= 1'b0;
      end else if (m_boot[k]) begin
        m_boot[k] <= 1'b0;
      end else if (rv) begin
        m_valid[k] <= 1'b0;
        if (rt % 4 != 0) begin
          m_fault[k] <= 1'b1;
          m_fa[k]    <= rt;
        end else begin
          m_pc[k] <= rt;
        end
      end else if (!m_valid[k] || ready) begin
        m_opc[k]   <= m_pc[k];
        m_ins[k]   <= mem_word(m_pc[k]);
        m_valid[k] <= 1'b1;
        m_pc[k]    <= m_pc[k] + 32'd4;
        m_cnt[k]   <= m_cnt[k] + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] a, input logic v,
                          input logic [31:0] opc, input logic [31:0] pp4,
                          input logic [31:0] ins, input logic f,
                          input logic [31:0] fa, input logic [31:0] fc,
                          input logic [31:0] fc_mask);
    chk($sformatf("m%0d_addr", k), a, m_pc[k]);
    chk($sformatf("m%0d_valid", k), {31'b0, v}, {31'b0, m_valid[k]});
    chk($sformatf("m%0d_out_pc", k), opc, m_opc[k]);
    chk($sformatf("m%0d_pc_plus4", k), pp4, m_opc[k] + 32'd4);
    chk($sformatf("m%0d_instr", k), ins, m_ins[k]);
    chk($sformatf("m%0d_fault", k), {31'b0, f}, {31'b0, m_fault[k]});
    chk($sformatf("m%0d_fault_addr", k), fa, m_fa[k]);
    chk($sformatf("m%0d_count", k), fc, m_cnt[k] & fc_mask);
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #1;
    cmp_inst(0, addr0, v0, opc0, pp40, ins0, f0, fa0, fc0, 32'hFFFFFFFF);
    cmp_inst(1, addr1, v1, opc1, pp41, ins1, f1, fa1, {28'b0, fc1}, 32'h0000000F);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [15:0] pattern;

  initial begin
    rst_n = 1'b0; ready = 1'b1; rv = 1'b0; rt = 32'h0;
    pattern = 16'b1011_0010_0111_0001;
    @(negedge clk);
    chk("rst_addr0", addr0, 32'h0);
    chk("rst_addr1", addr1, 32'h100);
    chk("rst_valid0", {31'b0, v0}, 32'h0);
    chk("rst_instr0", ins0, 32'h00000013);
    chk("rst_count0", fc0, 32'h0);
    rst_n = 1'b1;

    tick(); chk("boot_bubble", {31'b0, v0}, 32'h0);
    tick(); chk("first_valid", {31'b0, v0}, 32'h1); chk("first_pc", opc0, 32'h0);
    tick(); chk("second_pc", opc0, 32'h4);
    tick(); chk("third_pc", opc0, 32'h8); chk("count3", fc0, 32'd3);
    chk("addr12", addr0, 32'hC);

    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", opc0, 32'h8);
      chk("stall_instr", ins0, 32'h00200013);
      chk("stall_addr", addr0, 32'hC);
      chk("stall_count", fc0, 32'd3);
    end
    ready = 1'b1;
    tick(); chk("resume_pc", opc0, 32'hC);

    rv = 1'b1; rt = 32'h44;
    tick(); rv = 1'b0;
    chk("redir_flush", {31'b0, v0}, 32'h0); chk("redir_addr", addr0, 32'h44);
    chk("redir_count", fc0, 32'd4);
    tick(); chk("redir_pc", opc0, 32'h44); chk("redir_valid", {31'b0, v0}, 32'h1);

    rv = 1'b1; rt = 32'hFFFFFFFC;
    tick(); rv = 1'b0;
    tick(); chk("wrap_pc", opc0, 32'hFFFFFFFC); chk("wrap_plus4", pp40, 32'h0);
    chk("wrap_addr", addr0, 32'h0);
    tick(); chk("after_wrap_pc", opc0, 32'h0);

    rv = 1'b1; rt = 32'h46;
    tick();
    chk("fault_set", {31'b0, f0}, 32'h1); chk("fault_addr", fa0, 32'h46);
    chk("fault_valid", {31'b0, v0}, 32'h0); chk("fault_pc_hold", addr0, 32'h4);
    for (int i = 0; i < 6; i++) begin
      rv = (i % 2 == 0); rt = 32'h40 * i; ready = ~ready;
      tick();
      chk("fault_sticky", {31'b0, f0}, 32'h1);
      chk("fault_addr_hold", addr0, 32'h4);
      chk("fault_no_valid", {31'b0, v0}, 32'h0);
    end
    rv = 1'b0; ready = 1'b1;

    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("fault_cleared", {31'b0, f0}, 32'h0);
    repeat (20) tick();
    for (int i = 0; i < 16; i++) begin
      ready = pattern[i];
      tick();
    end

    ready = 1'b0;
    tick(); tick();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_addr0", addr0, 32'h0);
    chk("async_addr1", addr1, 32'h100);
    chk("async_valid0", {31'b0, v0}, 32'h0);
    chk("async_pc0", opc0, 32'h0);
    chk("async_instr0", ins0, 32'h00000013);
    chk("async_count0", fc0, 32'h0);
    chk("async_count1", {28'b0, fc1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    tick(); tick();
    chk("restart_pc1", opc1, 32'h100); chk("restart_addr1", addr1, 32'h104);
    chk("restart_pc0", opc0, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, meaning the width of the fetch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port instr_addr, output, 32 bits: the current PC, driven to the instruction memory address input.
REQ-006 SHALL have port instr_data, input, 32 bits: the instruction returned combinationally by the memory for instr_addr.
REQ-007 SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect request.
REQ-008 SHALL have port redirect_target, input, 32 bits: the redirect byte address.
REQ-009 SHALL have port out_valid, output, 1 bit: the output register holds a fetched instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: the decode stage accepts the output this cycle.
REQ-011 SHALL have port out_pc, output, 32 bits: the PC of the held instruction.
REQ-012 SHALL have port out_pc_plus4, output, 32 bits: out_pc + 4, modulo 2^32, used as the jal/jalr link value.
REQ-013 SHALL have port out_instr, output, 32 bits: the held instruction word.
REQ-014 SHALL have port fault, output, 1 bit: a misaligned-redirect fault is latched.
REQ-015 SHALL have port fault_addr, output, 32 bits: the offending redirect target.
REQ-016 SHALL have port fetch_count, output, COUNT_WIDTH bits: the number of instructions captured.

Function
REQ-017 SHALL implement states BOOT, RUN and FAULT; instr_addr SHALL equal the PC register in every state.
REQ-018 In BOOT, the block SHALL perform no capture, and the next state SHALL be RUN unconditionally (one bubble cycle after reset release).
REQ-019 In RUN, load SHALL be defined as (!out_valid || out_ready); the block SHALL stall by holding the PC and all out_* outputs when load=0.
REQ-020 In RUN with load=1 and no redirect, the block SHALL perform these updates on the same edge:
- out_pc <= PC
- out_instr <= instr_data
- out_valid <= 1
- PC <= PC + 4, wrapping from 32'hFFFFFFFC to 0
- fetch_count++, wrapping modulo 2^COUNT_WIDTH
REQ-021 A redirect in RUN SHALL take priority over capture and ignore out_ready; on it:
- out_valid <= 0 (flush)
- PC <= redirect_target
- fetch_count unchanged
REQ-022 If redirect_valid=1 in RUN and redirect_target[1:0] != 0, the block SHALL:
- enter FAULT
- set fault <= 1
- set fault_addr <= redirect_target
- set out_valid <= 0
- leave the PC unchanged
REQ-023 FAULT SHALL be terminal until reset, with out_valid=0 and all inputs ignored.
REQ-024 redirect_valid in BOOT SHALL be ignored.
REQ-025 A redirect accepted while out_valid=1 and out_ready=1 SHALL still flush, i.e. the held instruction is consumed by decode and no new capture occurs.
REQ-026 out_pc_plus4 SHALL be combinational from out_pc.
REQ-027 The block SHALL not check instr_data contents; out-of-range handling belongs to the memory.

Reset
REQ-028 While rst_n=0, the block SHALL immediately set:
- state = BOOT
- PC = RESET_PC
- out_valid = 0
- out_pc = 0
- out_instr = 32'h00000013
- fault = 0
- fault_addr = 0
- fetch_count = 0
REQ-029 Reset asserted mid-stall, mid-redirect or in FAULT SHALL abort all activity with no partial update surviving.

Verification
REQ-030 The bench SHALL cover reset release with out_ready=1 and memory returning addi words -> out_valid rises on the 2nd edge, out_pc sequence 0,4,8,..., and fetch_count=3 after the 4th edge.
REQ-031 The bench SHALL cover out_ready=0 for 3 cycles with out_valid=1 and out_pc=8 -> out_pc, out_instr and instr_addr=12 are held, and fetch_count is unchanged.
REQ-032 The bench SHALL cover redirect_valid=1 with target 32'h44 while out_pc=12 -> the next edge gives out_valid=0 and instr_addr=32'h44, and the following edge gives out_pc=32'h44.
REQ-033 The bench SHALL cover redirect target 32'h46 -> fault=1, fault_addr=32'h46 and out_valid=0 permanently, and instr_addr is unchanged until rst_n pulses low.
REQ-034 The bench SHALL cover PC=32'hFFFFFFFC captured -> next instr_addr=0 and out_pc_plus4=0.
REQ-035 The bench SHALL cover rst_n asserted asynchronously between edges during a stall -> outputs take reset values before the next edge, and RESET_PC=32'h100 restarts the fetch at 32'h100.
